// File: rtl/seg_pkg.sv
// Shared types, segment patterns and width helpers for the seven-segment scan driver.
// All segment patterns are active-low, bit6 = a ... bit0 = g.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex glyphs, listed from code F down to code 0 so element [n] is code n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    localparam logic [3:0] OP_PLUS = 4'd0;
    localparam logic [3:0] OP_MIN  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_O    = 4'd4;
    localparam logic [3:0] OP_H    = 4'd5;
    localparam logic [3:0] OP_EQ   = 4'd6;

    // Operator glyphs for codes 7 down to 0; slot 7 is padding so a 3-bit index is always legal.
    localparam logic [7:0][6:0] SEG_OP = {
        SEG_BLANK,  7'b1110110, 7'b1101000, 7'b0000001,
        7'b1011011, 7'b1001000, 7'b1111110, 7'b1101100
    };

    typedef struct packed {
        logic [3:0] code;
        logic       typ;
        logic       valid;
    } seg_entry_t;

    function automatic int unsigned count_width(input int unsigned ndig);
        return $clog2(ndig + 1);
    endfunction

    // Counter width for a modulus, never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph lookup for one buffered character: hex or operator, blank when invalid.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_type,
    input  logic       i_valid,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg;

    always_comb begin
        w_seg = SEG_BLANK;
        if (i_valid) begin
            if (i_type) begin
                w_seg = SEG_HEX[i_code];
            end else if (!i_code[3]) begin
                w_seg = SEG_OP[i_code[2:0]];
            end
        end
    end

    assign o_seg = w_seg;

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver: shift buffer fed by a push interface,
// digit scanner with prescaler, and an optional blinking cursor on digit 0.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_SCANS = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    input  logic [3:0]                    push_code,
    input  logic                          push_type,
    output logic                          push_ready,
    input  logic                          clr,
    input  logic                          blink_en,
    output logic [count_width(NDIG)-1:0]  count,
    output logic [NDIG-1:0]               an,
    output logic [6:0]                    CSseg
);

    localparam int unsigned CW = count_width(NDIG);
    localparam int unsigned PW = ctr_width(SCAN_DIV);
    localparam int unsigned IW = ctr_width(NDIG);
    localparam int unsigned FW = ctr_width(BLINK_SCANS);

    seg_entry_t      r_buf [NDIG];
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_presc;
    logic [IW-1:0]   r_idx;
    logic [FW-1:0]   r_frame;
    logic            r_blink_hide;
    logic [NDIG-1:0] r_an;
    logic [6:0]      r_seg;

    logic            w_push;
    logic            w_presc_tc;
    logic            w_idx_last;
    logic            w_frame_tc;
    seg_entry_t      w_cur;
    logic [6:0]      w_dec;
    logic [NDIG-1:0] w_an;
    logic            w_cursor_off;

    assign push_ready = (r_count < CW'(NDIG));
    assign w_push     = push_valid & push_ready & ~clr;

    assign w_presc_tc = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IW'(NDIG - 1));
    assign w_frame_tc = (r_frame == FW'(BLINK_SCANS - 1));

    // Character buffer: newest entry at digit 0, older entries shift left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                r_buf[i] <= '0;
            end
            r_count <= '0;
        end else if (clr) begin
            for (int i = 0; i < NDIG; i++) begin
                r_buf[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else if (w_push) begin
            for (int i = NDIG - 1; i > 0; i--) begin
                r_buf[i] <= r_buf[i-1];
            end
            r_buf[0] <= '{code: push_code, typ: push_type, valid: 1'b1};
            r_count  <= r_count + 1'b1;
        end
    end

    // Scan timing is free-running and deliberately ignores clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame      <= '0;
            r_blink_hide <= 1'b0;
        end else begin
            if (w_presc_tc) begin
                r_presc <= '0;
                if (w_idx_last) begin
                    r_idx <= '0;
                    if (w_frame_tc) begin
                        r_frame      <= '0;
                        r_blink_hide <= ~r_blink_hide;
                    end else begin
                        r_frame <= r_frame + 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign w_cur = r_buf[r_idx];

    seg_decode u_decode (
        .i_code  (w_cur.code),
        .i_type  (w_cur.typ),
        .i_valid (w_cur.valid),
        .o_seg   (w_dec)
    );

    assign w_an         = ~({{(NDIG-1){1'b0}}, 1'b1} << r_idx);
    assign w_cursor_off = blink_en & (r_idx == '0) & r_blink_hide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_cursor_off ? SEG_BLANK : w_dec;
        end
    end

    assign count = r_count;
    assign an    = r_an;
    assign CSseg = r_seg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display against a time-based reference model.
module tb_seg_scan_display;

    localparam int NDIG        = 4;
    localparam int SCAN_DIV    = 4;
    localparam int BLINK_SCANS = 2;
    localparam int CW          = $clog2(NDIG + 1);
    localparam int FRAME       = NDIG * SCAN_DIV;

    logic            clk        = 1'b0;
    logic            rst        = 1'b0;
    logic            push_valid = 1'b0;
    logic [3:0]      push_code  = 4'd0;
    logic            push_type  = 1'b0;
    logic            clr        = 1'b0;
    logic            blink_en   = 1'b0;
    logic            push_ready;
    logic [CW-1:0]   count;
    logic [NDIG-1:0] an;
    logic [6:0]      CSseg;

    int n_err = 0;
    int n_chk = 0;

    // Model: q[0] is digit 0, each element {type, code}; t counts edges since reset.
    logic [4:0]      q[$];
    int              t = 0;
    logic [NDIG-1:0] exp_an  = '1;
    logic [6:0]      exp_seg = 7'b1111111;

    seg_scan_display #(
        .NDIG        (NDIG),
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_SCANS (BLINK_SCANS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_code  (push_code),
        .push_type  (push_type),
        .push_ready (push_ready),
        .clr        (clr),
        .blink_en   (blink_en),
        .count      (count),
        .an         (an),
        .CSseg      (CSseg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [4:0] ch);
        logic [3:0] c;
        c = ch[3:0];
        if (ch[4]) begin
            case (c)
                4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
                4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
                4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
                4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
                4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
                4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
                4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
                4'hE: return 7'b0110000;  default: return 7'b0111000;
            endcase
        end
        case (c)
            4'd0: return 7'b1101100;  4'd1: return 7'b1111110;
            4'd2: return 7'b1001000;  4'd3: return 7'b1011011;
            4'd4: return 7'b0000001;  4'd5: return 7'b1101000;
            4'd6: return 7'b1110110;  default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [NDIG-1:0] ref_an(input int tt);
        logic [NDIG-1:0] one;
        one = 1;
        return ~(one << ((tt / SCAN_DIV) % NDIG));
    endfunction

    function automatic logic [6:0] ref_disp(input int tt);
        int d;
        bit hide;
        d    = (tt / SCAN_DIV) % NDIG;
        hide = (((tt / FRAME) / BLINK_SCANS) % 2) == 1;
        if (blink_en && d == 0 && hide) return 7'b1111111;
        if (d < int'(q.size())) return ref_seg(q[d]);
        return 7'b1111111;
    endfunction

    // Drive one cycle of inputs, advance one edge, and update the model.
    task automatic tick(input logic pv, input logic [3:0] cd, input logic ty, input logic cl);
        logic [NDIG-1:0] n_an;
        logic [6:0]      n_seg;
        push_valid = pv;
        push_code  = cd;
        push_type  = ty;
        clr        = cl;
        n_an  = ref_an(t);
        n_seg = ref_disp(t);
        @(posedge clk);
        #1;
        exp_an  = n_an;
        exp_seg = n_seg;
        if (cl) q.delete();
        else if (pv && q.size() < NDIG) q.push_front({ty, cd});
        t++;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        t = 0;
        exp_an  = '1;
        exp_seg = 7'b1111111;
        n_chk++; if (an !== 4'b1111) begin
            n_err++; $display("FAIL reset_an got=%b want=1111", an);
        end
        n_chk++; if (CSseg !== 7'b1111111) begin
            n_err++; $display("FAIL reset_seg got=%b want=1111111", CSseg);
        end
        n_chk++; if (count !== '0) begin
            n_err++; $display("FAIL reset_count got=%0d want=0", count);
        end
        n_chk++; if (push_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got=%b want=1", push_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        tick(1'b1, 4'h3, 1'b1, 1'b0);
        tick(1'b1, 4'hA, 1'b1, 1'b0);
        push_valid = 1'b0;
        n_chk++; if (count !== CW'(2)) begin
            n_err++; $display("FAIL basic_count got=%0d want=2", count);
        end
        for (int i = 0; i < FRAME + 2; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n_chk++; if (an !== exp_an || CSseg !== exp_seg) begin
                n_err++;
                $display("FAIL basic_scan t=%0d an=%b want=%b seg=%b want=%b",
                         t, an, exp_an, CSseg, exp_seg);
            end
            if (exp_an == 4'b1110) begin
                n_chk++; if (CSseg !== 7'b0001000) begin
                    n_err++; $display("FAIL basic_digit0 got=%b want=0001000", CSseg);
                end
            end
            if (exp_an == 4'b1101) begin
                n_chk++; if (CSseg !== 7'b0000110) begin
                    n_err++; $display("FAIL basic_digit1 got=%b want=0000110", CSseg);
                end
            end
        end
    endtask

    task automatic test_fill();
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            if (i == 3) begin
                n_chk++; if (push_ready !== 1'b0 || count !== CW'(4)) begin
                    n_err++;
                    $display("FAIL fill_full ready=%b want=0 count=%0d want=4", push_ready, count);
                end
            end
        end
        n_chk++; if (count !== CW'(4) || int'(q.size()) != 4) begin
            n_err++; $display("FAIL fill_ignore count=%0d want=4", count);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n_chk++; if (an !== exp_an || CSseg !== exp_seg) begin
                n_err++;
                $display("FAIL fill_scan t=%0d an=%b want=%b seg=%b want=%b",
                         t, an, exp_an, CSseg, exp_seg);
            end
        end
    endtask

    task automatic test_clr_push();
        tick(1'b1, 4'h5, 1'b1, 1'b1);
        n_chk++; if (count !== '0 || push_ready !== 1'b1) begin
            n_err++; $display("FAIL clr_wins count=%0d want=0 ready=%b want=1", count, push_ready);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n_chk++; if (an !== exp_an || CSseg !== 7'b1111111) begin
                n_err++;
                $display("FAIL clr_scan t=%0d an=%b want=%b seg=%b want=1111111",
                         t, an, exp_an, CSseg);
            end
        end
    endtask

    task automatic test_operator();
        tick(1'b1, 4'd6, 1'b0, 1'b0);
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        n_chk++; if (count !== CW'(2)) begin
            n_err++; $display("FAIL op_count got=%0d want=2", count);
        end
        for (int i = 0; i < FRAME + 1; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n_chk++; if (an !== exp_an || CSseg !== exp_seg) begin
                n_err++;
                $display("FAIL op_scan t=%0d an=%b want=%b seg=%b want=%b",
                         t, an, exp_an, CSseg, exp_seg);
            end
            if (exp_an == 4'b1101) begin
                n_chk++; if (CSseg !== 7'b1110110) begin
                    n_err++; $display("FAIL op_equals got=%b want=1110110", CSseg);
                end
            end
        end
    endtask

    task automatic test_blink();
        tick(1'b1, 4'h8, 1'b1, 1'b0);
        blink_en = 1'b1;
        for (int i = 0; i < 3 * FRAME * BLINK_SCANS + 4; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n_chk++; if (an !== exp_an || CSseg !== exp_seg) begin
                n_err++;
                $display("FAIL blink_scan t=%0d an=%b want=%b seg=%b want=%b",
                         t, an, exp_an, CSseg, exp_seg);
            end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
            tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            n_chk++; if (an !== exp_an || CSseg !== exp_seg) begin
                n_err++;
                $display("FAIL rand_scan t=%0d an=%b want=%b seg=%b want=%b",
                         t, an, exp_an, CSseg, exp_seg);
            end
            n_chk++; if (count !== CW'(q.size()) || push_ready !== (q.size() < NDIG)) begin
                n_err++;
                $display("FAIL rand_count t=%0d count=%0d want=%0d ready=%b",
                         t, count, q.size(), push_ready);
            end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_async_reset();
        tick(1'b1, 4'h1, 1'b1, 1'b0);
        tick(1'b1, 4'h2, 1'b1, 1'b0);
        repeat (5) tick(1'b0, 4'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (an !== 4'b1111 || CSseg !== 7'b1111111 || count !== '0) begin
            n_err++;
            $display("FAIL async_reset an=%b want=1111 seg=%b want=1111111 count=%0d want=0",
                     an, CSseg, count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        t = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n_chk++; if (an !== exp_an || CSseg !== exp_seg) begin
                n_err++;
                $display("FAIL post_reset t=%0d an=%b want=%b seg=%b want=%b",
                         t, an, exp_an, CSseg, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_clr_push();
        test_operator();
        test_blink();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Multi-digit, time-multiplexed seven-segment driver for the calculator front end.
- Accepts keypad characters (hex digit or operator code plus type flag) over a valid/ready push interface and holds them in an NDIG-deep shift buffer. New characters enter at the rightmost digit.
- Scans the digits at a programmable refresh rate and drives shared active-low cathodes plus active-low digit enables.
- Supports buffer clear and an optional blinking cursor on the rightmost digit.

Parameters:
- NDIG, 4, number of digits in the display and buffer (2..8).
- SCAN_DIV, 50000, clk cycles each digit is enabled per scan.
- BLINK_SCANS, 100, complete scan frames per blink half-period.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- push_valid  in  1  character offered.
- push_code  in  4  character code.
- push_type  in  1  1 = hex digit 0-F; 0 = operator code.
- push_ready  out  1  buffer can accept a character.
- clr  in  1  synchronous clear of all buffered characters.
- blink_en  in  1  enable cursor blink on digit 0.
- count  out  $clog2(NDIG+1)  number of valid characters held.
- an  out  NDIG  digit enables, active-low; bit i = digit i, digit 0 is rightmost.
- CSseg  out  7  segment cathodes, active-low; bit6 = a … bit0 = g.

Behaviour:
- Reset (async, rst=1):
  - All buffer entries invalid; count=0.
  - Prescaler=0, scan index=0, frame counter=0, blink phase=visible.
  - an = all ones; CSseg = 7'b1111111.
- Push:
  - push_ready = (count < NDIG), combinational from count.
  - A push is accepted when push_valid & push_ready & ~clr at a rising clk edge.
  - On accept, entry i takes entry i-1 for i = NDIG-1..1, and entry 0 takes {push_code, push_type, valid}. count increments.
  - A push while full is ignored; buffer and count are unchanged.
- Clear:
  - clr=1 invalidates all entries and sets count=0 on the next edge.
  - clr wins over a simultaneous push.
  - Scan and blink counters are not affected by clr.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the scan index advances (NDIG-1 wraps to 0).
  - When the index wraps, the frame counter advances. At BLINK_SCANS-1 the frame counter wraps and blink phase toggles.
- Output (registered, updated every cycle from the current index and buffer):
  - an = ~(1 << index).
  - CSseg = decode(entry[index]) when the entry is valid, otherwise blank.
  - Blank override: if blink_en=1, index=0 and blink phase=hidden, CSseg = blank.
  - Latency: a buffer or index change appears on an/CSseg one clk later.
  - While blink_en=0 the blink phase keeps toggling but is ignored.
- Decode (hex, type=1), active-low patterns:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110
  - 4 → 1001100, 5 → 0100100, 6 → 0100000, 7 → 0001111
  - 8 → 0000000, 9 → 0000100, A → 0001000, b → 1100000
  - C → 0110001, d → 1000010, E → 0110000, F → 0111000
- Decode (operator, type=0), active-low patterns:
  - 0 + → 1101100, 1 - → 1111110, 2 * → 1001000, 3 / → 1011011
  - 4 o → 0000001, 5 h → 1101000, 6 = → 1110110
  - 7-15 → blank (1111111).
- Reset mid-scan forces the outputs blank and all digits off immediately (asynchronous).

Decomposition:
- Package seg_pkg holds:
  - the segment pattern constants (hex set, operator set, SEG_BLANK);
  - operator code localparams OP_PLUS=0, OP_MIN=1, OP_MULT=2, OP_DIV=3, OP_O=4, OP_H=5, OP_EQ=6;
  - the function/width helper for count.
- Sub-module seg_decode (combinational) maps code/type/valid to a 7-bit pattern. It is instantiated once, on the muxed entry.

Test Plan:
- Reset with SCAN_DIV=4, NDIG=4 → an=4'b1111, CSseg=7'b1111111, count=0, push_ready=1.
- Push hex 3, then hex A → count=2. While index=0: an=4'b1110, CSseg=0001000. While index=1: an=4'b1101, CSseg=0000110. Digits 2-3 blank.
- Push five characters with push_valid held high → the fourth push sets push_ready=0 and count=4. The fifth is ignored; entry 0 still holds the fourth character.
- clr and push_valid asserted in the same cycle → count=0, all digits blank, scan continues without a glitch in an sequence.
- Push operator 6, then operator 9 → "=" shows as 1110110; code 9 shows blank while count=2.
- Set blink_en=1, BLINK_SCANS=2 → digit 0 CSseg alternates visible/1111111 every 2 frames (32 clk); the other digits are unaffected.
